// File: rtl/ex_trig_scheduler.sv
// External trigger scheduler: rising-edge capture per source, round-robin grant of one
// shared acquisition engine via req/ack, programmable dead time, saturating drop counter.
module ex_trig_scheduler #(
    parameter int N_SRC     = 4,
    parameter int SRC_W     = 2,
    parameter int HOLDOFF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     sig_sync,
    input  logic [N_SRC-1:0]     src_en,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 acq_req,
    output logic [SRC_W-1:0]     acq_src,
    input  logic                 acq_ack,
    output logic [N_SRC-1:0]     pend,
    output logic                 busy,
    output logic [15:0]          drop_cnt
);

    localparam int DROP_W = $clog2(N_SRC + 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t               state;
    logic [N_SRC-1:0]     prev;
    logic [N_SRC-1:0]     edge_det;
    logic [N_SRC-1:0]     eligible;
    logic [N_SRC-1:0]     ack_clr;
    logic [N_SRC-1:0]     en_clr;
    logic [N_SRC-1:0]     drop_vec;
    logic [N_SRC-1:0]     pend_nxt;
    logic [DROP_W-1:0]    drop_num;
    logic [HOLDOFF_W-1:0] cnt;
    logic [SRC_W-1:0]     ptr;
    logic [SRC_W-1:0]     grant;
    logic                 grant_vld;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [DROP_W-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        edge_det = sig_sync & ~prev & src_en;
        ack_clr  = '0;
        if (state == REQ && acq_ack)
            ack_clr[acq_src] = 1'b1;
        // The granted source keeps its pend bit until ack even if it gets disabled.
        en_clr = ~src_en;
        if (state == REQ)
            en_clr[acq_src] = 1'b0;
        // A set in the ack cycle wins over the clear and is not a drop.
        drop_vec = edge_det & pend & ~ack_clr;
        pend_nxt = (pend & ~ack_clr & ~en_clr) | edge_det;
        drop_num = '0;
        for (int i = 0; i < N_SRC; i++)
            drop_num = drop_num + DROP_W'(drop_vec[i]);
    end

    // Disabled sources are not eligible even in the cycle before their pend bit clears.
    assign eligible = pend & src_en;

    always_comb begin
        logic [SRC_W-1:0] idx;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = SRC_W'((int'(ptr) + k) % N_SRC);
            if (!grant_vld && eligible[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acq_req  <= 1'b0;
            acq_src  <= '0;
            pend     <= '0;
            busy     <= 1'b0;
            drop_cnt <= '0;
            cnt      <= '0;
            ptr      <= SRC_W'(N_SRC - 1);
            prev     <= '1;
        end else begin
            prev     <= sig_sync;
            pend     <= pend_nxt;
            drop_cnt <= sat_add(drop_cnt, drop_num);
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        acq_src <= grant;
                        ptr     <= grant;
                        acq_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (acq_ack) begin
                        acq_req <= 1'b0;
                        cnt     <= holdoff;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    acq_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
